// File: rtl/data_sampling_if.sv
// Serial-sampler signal bundle: raw line and control in, oversample counters and voted bit out.
// The master side drives the line and controls; the slave side is the sampler.
interface data_sampling_if #(
   parameter int unsigned PRESCALE_WIDTH = 6
);
   logic                      RX_IN;
   logic [PRESCALE_WIDTH-1:0] Prescale;
   logic                      Enable;
   logic [PRESCALE_WIDTH-1:0] edge_cnt;
   logic [3:0]                bit_cnt;
   logic                      sampled_bit;
   logic                      sample_valid;

   modport master (
      output RX_IN, Prescale, Enable,
      input  edge_cnt, bit_cnt, sampled_bit, sample_valid
   );

   modport slave (
      input  RX_IN, Prescale, Enable,
      output edge_cnt, bit_cnt, sampled_bit, sample_valid
   );
endinterface

// File: rtl/data_sampling.sv
// Oversampling UART bit sampler: synchronises RX_IN and takes three mid-bit samples.
// It emits a majority-voted bit with a one-cycle strobe once per bit period.
module data_sampling #(
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input logic            CLK,
   input logic            RST,
   data_sampling_if.slave bus
);
   localparam logic [PRESCALE_WIDTH-1:0] P8  = PRESCALE_WIDTH'(8);
   localparam logic [PRESCALE_WIDTH-1:0] P16 = PRESCALE_WIDTH'(16);
   localparam logic [PRESCALE_WIDTH-1:0] P32 = PRESCALE_WIDTH'(32);
   localparam logic [PRESCALE_WIDTH-1:0] One = PRESCALE_WIDTH'(1);
   localparam logic [PRESCALE_WIDTH-1:0] Two = PRESCALE_WIDTH'(2);

   logic                      sync1_q, rx_s;
   logic                      en_q;
   logic                      en_rise, wrap;
   logic [PRESCALE_WIDTH-1:0] p_q, p_d, half;
   logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
   logic [3:0]                bit_q, bit_d;
   logic                      s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic                      sbit_q, sbit_d;
   logic                      valid_q, valid_d;

   function automatic logic [PRESCALE_WIDTH-1:0] legal_p(input logic [PRESCALE_WIDTH-1:0] p);
      if (p == P16 || p == P32) return p;
      return P8;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_comb begin
      en_rise = bus.Enable & ~en_q;
      p_d     = en_rise ? legal_p(bus.Prescale) : p_q;
      half    = p_q >> 1;
      wrap    = (edge_q == p_q - One);
      edge_d  = '0;
      bit_d   = '0;
      valid_d = 1'b0;
      sbit_d  = sbit_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      // The rising cycle only restarts the counters; the new P governs from the next cycle on.
      if (bus.Enable && !en_rise) begin
         edge_d = wrap ? '0 : edge_q + One;
         bit_d  = (wrap && bit_q != 4'd15) ? bit_q + 4'd1 : bit_q;
         if (edge_q == half - Two) s0_d = rx_s;
         if (edge_q == half - One) s1_d = rx_s;
         if (edge_q == half) begin
            s2_d    = rx_s;
            sbit_d  = maj3(s0_q, s1_q, s2_d);
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= 1'b1;
         rx_s    <= 1'b1;
         en_q    <= 1'b0;
         p_q     <= P8;
         edge_q  <= '0;
         bit_q   <= '0;
         s0_q    <= 1'b1;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         sbit_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= bus.RX_IN;
         rx_s    <= sync1_q;
         en_q    <= bus.Enable;
         p_q     <= p_d;
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         sbit_q  <= sbit_d;
         valid_q <= valid_d;
      end
   end

   assign bus.edge_cnt     = edge_q;
   assign bus.bit_cnt      = bit_q;
   assign bus.sampled_bit  = sbit_q;
   assign bus.sample_valid = valid_q;
endmodule

// File: tb/tb_data_sampling.sv
// Bench for data_sampling: a time-based reference model checked every cycle.
// Directed scenarios add literal expectations at key points.
module tb_data_sampling;
   logic CLK;
   logic RST;
   int   checks   = 0;
   int   failures = 0;

   data_sampling_if #(.PRESCALE_WIDTH(6)) bus ();

   data_sampling #(.PRESCALE_WIDTH(6)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: t counts cycles since Enable was first seen high, so the counters
   // follow from t mod P and t div P; rx_s is RX_IN delayed two edges.
   int   m_t, m_p, m_edge, m_bit;
   bit   m_en_prev;
   logic m_sbit, m_valid;
   logic rin_q[$];
   logic rxs_q[$];

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_en_prev = 1'b0;
         m_p       = 8;
         m_t       = 0;
         m_edge    = 0;
         m_bit     = 0;
         m_sbit    = 1'b1;
         m_valid   = 1'b0;
         rin_q.delete();
         rin_q.push_back(1'b1);
         rin_q.push_back(1'b1);
         rxs_q.delete();
      end else begin
         rin_q.push_back(bus.RX_IN);
         rxs_q.push_back(rin_q[rin_q.size() - 3]);
         if (rin_q.size() > 3) void'(rin_q.pop_front());
         if (rxs_q.size() > 3) void'(rxs_q.pop_front());
         if (!bus.Enable) begin
            m_en_prev = 1'b0;
            m_edge    = 0;
            m_bit     = 0;
            m_valid   = 1'b0;
         end else begin
            if (!m_en_prev) begin
               m_p = (bus.Prescale == 6'd16 || bus.Prescale == 6'd32) ? int'(bus.Prescale) : 8;
               m_t = 0;
            end else begin
               m_t++;
            end
            m_en_prev = 1'b1;
            m_edge    = m_t % m_p;
            m_bit     = (m_t / m_p > 15) ? 15 : m_t / m_p;
            m_valid   = (m_edge == m_p / 2 + 1);
            if (m_valid)
               m_sbit = (int'(rxs_q[0]) + int'(rxs_q[1]) + int'(rxs_q[2])) >= 2;
         end
      end
   end

   always @(posedge CLK) begin
      #1;
      chk("model edge_cnt", 32'(bus.edge_cnt), 32'(m_edge));
      chk("model bit_cnt", 32'(bus.bit_cnt), 32'(m_bit));
      chk("model sampled_bit", 32'(bus.sampled_bit), 32'(m_sbit));
      chk("model sample_valid", 32'(bus.sample_valid), 32'(m_valid));
   end

   task automatic strobe_chk(input string name, input int edge_exp, input int bit_exp,
                             input logic sbit_exp);
      chk({name, " valid"}, 32'(bus.sample_valid), 32'd1);
      chk({name, " edge"}, 32'(bus.edge_cnt), 32'(edge_exp));
      chk({name, " bit"}, 32'(bus.bit_cnt), 32'(bit_exp));
      chk({name, " sbit"}, 32'(bus.sampled_bit), 32'(sbit_exp));
   endtask

   task automatic disable_gap();
      @(negedge CLK);
      bus.Enable = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      logic [3:0] frame;
      frame        = 4'b1010;  // bit b of the frame is frame[b]: 0,1,0,1
      RST          = 1'b1;
      bus.RX_IN    = 1'b1;
      bus.Enable   = 1'b0;
      bus.Prescale = 6'd8;
      #3;
      chk("reset edge", 32'(bus.edge_cnt), 32'd0);
      chk("reset bit", 32'(bus.bit_cnt), 32'd0);
      chk("reset sbit", 32'(bus.sampled_bit), 32'd1);
      chk("reset valid", 32'(bus.sample_valid), 32'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      // P=8, line held low: strobes at edge 5, bit_cnt 0,1,2
      @(negedge CLK);
      bus.Prescale = 6'd8;
      bus.RX_IN    = 1'b0;
      bus.Enable   = 1'b1;
      repeat (6) @(posedge CLK);
      #1 strobe_chk("p8 bit0", 5, 0, 1'b0);
      repeat (8) @(posedge CLK);
      #1 strobe_chk("p8 bit1", 5, 1, 1'b0);
      repeat (8) @(posedge CLK);
      #1 strobe_chk("p8 bit2", 5, 2, 1'b0);
      disable_gap();
      chk("idle edge", 32'(bus.edge_cnt), 32'd0);
      chk("idle bit", 32'(bus.bit_cnt), 32'd0);
      chk("idle sbit held", 32'(bus.sampled_bit), 32'd0);

      // P=32, frame 0,1,0,1: first strobe 18 cycles in, then every 32
      bus.Prescale = 6'd32;
      bus.Enable   = 1'b1;
      for (int b = 0; b < 4; b++) begin
         bus.RX_IN = frame[b];
         repeat (18) @(posedge CLK);
         #1 strobe_chk("p32 frame", 17, b, frame[b]);
         repeat (15) @(negedge CLK);
      end
      disable_gap();

      // P=16: single-cycle high on rx_s at edge 7 is voted out
      bus.Prescale = 6'd16;
      bus.RX_IN    = 1'b0;
      bus.Enable   = 1'b1;
      repeat (6) @(negedge CLK);
      bus.RX_IN = 1'b1;
      @(negedge CLK);
      bus.RX_IN = 1'b0;
      repeat (3) @(posedge CLK);
      #1 strobe_chk("p16 glitch", 9, 0, 1'b0);
      // two of three samples high wins the vote
      repeat (13) @(negedge CLK);
      bus.RX_IN = 1'b1;
      repeat (2) @(negedge CLK);
      bus.RX_IN = 1'b0;
      repeat (2) @(posedge CLK);
      #1 strobe_chk("p16 two-high", 9, 1, 1'b1);
      disable_gap();

      // Illegal Prescale=13 behaves as 8
      bus.Prescale = 6'd13;
      bus.RX_IN    = 1'b1;
      bus.Enable   = 1'b1;
      repeat (6) @(posedge CLK);
      #1 strobe_chk("p13", 5, 0, 1'b1);
      repeat (2) @(posedge CLK);
      #1 chk("p13 edge7", 32'(bus.edge_cnt), 32'd7);
      @(posedge CLK);
      #1 chk("p13 wrap edge", 32'(bus.edge_cnt), 32'd0);
      chk("p13 wrap bit", 32'(bus.bit_cnt), 32'd1);
      disable_gap();

      // Prescale 8->16 mid-frame takes effect only after Enable re-rises
      bus.Prescale = 6'd8;
      bus.RX_IN    = 1'b0;
      bus.Enable   = 1'b1;
      repeat (10) @(negedge CLK);
      bus.Prescale = 6'd16;
      repeat (4) @(posedge CLK);
      #1 strobe_chk("mid change", 5, 1, 1'b0);
      repeat (3) @(posedge CLK);
      #1 chk("mid change wrap", 32'(bus.edge_cnt), 32'd0);
      chk("mid change bit", 32'(bus.bit_cnt), 32'd2);
      @(negedge CLK);
      bus.Enable = 1'b0;
      @(negedge CLK);
      bus.Enable = 1'b1;
      repeat (10) @(posedge CLK);
      #1 strobe_chk("recapture p16", 9, 0, 1'b0);
      disable_gap();

      // RST at edge 3 clears outputs at once; Enable high at release restarts the frame
      bus.Prescale = 6'd8;
      bus.Enable   = 1'b1;
      repeat (4) @(posedge CLK);
      #1 chk("pre-reset edge", 32'(bus.edge_cnt), 32'd3);
      #1 RST = 1'b1;
      #1;
      chk("async reset edge", 32'(bus.edge_cnt), 32'd0);
      chk("async reset bit", 32'(bus.bit_cnt), 32'd0);
      chk("async reset sbit", 32'(bus.sampled_bit), 32'd1);
      chk("async reset valid", 32'(bus.sample_valid), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (6) @(posedge CLK);
      #1 strobe_chk("post-reset", 5, 0, 1'b0);
      repeat (160) @(posedge CLK);
      #1 chk("bit_cnt saturate", 32'(bus.bit_cnt), 32'd15);
      disable_gap();
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
